// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type, parity encodings and clog2 helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO with registered full/empty/level and sticky overflow
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [clog2(FIFO_DEPTH):0]   level,
    output logic                         overflow
);

    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              push;
    logic              pop;

    // Acceptance looks only at the registered flags, never at a same-cycle pop.
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LVL_W'(1);
        end else if (pop && !push) begin
            level_next = level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            full  <= (level_next == LVL_W'(FIFO_DEPTH));
            empty <= (level_next == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter: FIFO front end, frame FSM, bit timer and parity
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 5208,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [clog2(FIFO_DEPTH):0]   level,
    output logic                         overflow,
    output logic                         busy,
    output logic                         rts,
    output logic                         tx
);

    localparam int TMR_W = clog2(CLK_DIV);
    localparam int BIT_W = clog2(DATA_W);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [TMR_W-1:0]  timer;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] fifo_data;
    logic              par_bit;
    logic              tx_next;
    logic              fifo_rd;
    logic              bit_done;
    logic              last_data;
    logic              last_stop;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    assign bit_done  = (timer == TMR_W'(CLK_DIV - 1));
    assign last_data = (bit_cnt == BIT_W'(DATA_W - 1));
    assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign busy      = (state != ST_IDLE) | ~empty;
    assign rts       = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx_next is the line level for the cycle after the edge, so tx stays a plain flop.
    always_comb begin
        state_next = state;
        tx_next    = tx;
        fifo_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    fifo_rd    = 1'b1;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (!last_data) begin
                        tx_next = shift_reg[1];
                    end else if (PARITY != PAR_NONE) begin
                        state_next = ST_PAR;
                        tx_next    = par_bit;
                    end else begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (bit_done && last_stop) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx        <= 1'b1;
            timer     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            tx <= tx_next;
            if (fifo_rd) begin
                shift_reg <= fifo_data;
                par_bit   <= (PARITY == PAR_ODD) ? ~(^fifo_data) : ^fifo_data;
            end else if (state == ST_DATA && bit_done) begin
                shift_reg <= shift_reg >> 1;
            end
            // bit_cnt indexes data bits in DATA and stop bits in STOP.
            if (state == ST_IDLE) begin
                timer   <= '0;
                bit_cnt <= '0;
            end else if (bit_done) begin
                timer   <= '0;
                bit_cnt <= (state_next != state) ? '0 : bit_cnt + BIT_W'(1);
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

endmodule
